// File: rtl/vx_mem_responder.sv
// Memory-bus slave: line array with byte-enabled writes, fixed-latency in-order reads.
// Optional MEM_RESPONDER_PERF_EN adds read/write/stall performance counters.
module vx_mem_responder #(
  parameter int DATA_SIZE      = 64,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int NUM_LINES      = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_rw,
  input  logic [DATA_SIZE-1:0]   req_byteen,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [8*DATA_SIZE-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [8*DATA_SIZE-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   rsp_ready
`ifdef MEM_RESPONDER_PERF_EN
  ,
  output logic [63:0]            perf_reads,
  output logic [63:0]            perf_writes,
  output logic [63:0]            perf_stalls
`endif
);
  localparam int DATA_W = 8 * DATA_SIZE;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int QW     = $clog2(RSP_QUEUE_SIZE);

  logic [DATA_W-1:0]    mem [NUM_LINES];
  logic [IDX_W-1:0]     idx;
  logic                 rd_fire, wr_fire, rsp_fire;
  logic [QW:0]          outstanding;
  logic                 push;
  logic [DATA_W-1:0]    push_dat;
  logic [TAG_WIDTH-1:0] push_tag;

  assign idx      = req_addr[IDX_W-1:0];
  assign req_ready = !reset && (outstanding < (QW+1)'(RSP_QUEUE_SIZE));
  assign rd_fire  = req_valid && req_ready && !req_rw;
  assign wr_fire  = req_valid && req_ready && req_rw;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (wr_fire)
      for (int b = 0; b < DATA_SIZE; b++)
        if (req_byteen[b]) mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
  end

  // Accept cycle counts as the first latency stage, so LATENCY-1 registers precede the queue.
  generate
    if (LATENCY == 1) begin : g_nopipe
      assign push     = rd_fire;
      assign push_dat = mem[idx];
      assign push_tag = req_tag;
    end else begin : g_pipe
      logic [LATENCY-2:0]   vld_pipe;
      logic [DATA_W-1:0]    dat_pipe [LATENCY-1];
      logic [TAG_WIDTH-1:0] tag_pipe [LATENCY-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe <= '0;
        else begin
          vld_pipe[0] <= rd_fire;
          for (int i = 1; i < LATENCY-1; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dat_pipe[0] <= mem[idx];
        tag_pipe[0] <= req_tag;
        for (int i = 1; i < LATENCY-1; i++) begin
          dat_pipe[i] <= dat_pipe[i-1];
          tag_pipe[i] <= tag_pipe[i-1];
        end
      end

      assign push     = vld_pipe[LATENCY-2];
      assign push_dat = dat_pipe[LATENCY-2];
      assign push_tag = tag_pipe[LATENCY-2];
    end
  endgenerate

  // Response queue; the outstanding bound guarantees it never overflows.
  logic [DATA_W-1:0]    q_dat [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] q_tag [RSP_QUEUE_SIZE];
  logic [QW:0]          wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      q_dat[wr_ptr[QW-1:0]] <= push_dat;
      q_tag[wr_ptr[QW-1:0]] <= push_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + (QW+1)'(1);
      if (rsp_fire) rd_ptr <= rd_ptr + (QW+1)'(1);
      case ({rd_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + (QW+1)'(1);
        2'b01:   outstanding <= outstanding - (QW+1)'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign rsp_valid = (wr_ptr != rd_ptr);
  assign rsp_data  = rsp_valid ? q_dat[rd_ptr[QW-1:0]] : '0;
  assign rsp_tag   = rsp_valid ? q_tag[rd_ptr[QW-1:0]] : '0;

`ifdef MEM_RESPONDER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_fire)                perf_reads  <= perf_reads + 64'd1;
      if (wr_fire)                perf_writes <= perf_writes + 64'd1;
      if (req_valid && !req_ready) perf_stalls <= perf_stalls + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Bench for vx_mem_responder: vector table, scoreboard of expected responses, corner sequences.
module tb_vx_mem_responder;
  logic         clk = 0;
  logic         reset;
  logic         req_valid, req_rw, req_ready;
  logic [63:0]  req_byteen;
  logic [25:0]  req_addr;
  logic [511:0] req_data;
  logic [7:0]   req_tag;
  logic         rsp_valid, rsp_ready;
  logic [511:0] rsp_data;
  logic [7:0]   rsp_tag;
`ifdef MEM_RESPONDER_PERF_EN
  logic [63:0]  perf_reads, perf_writes, perf_stalls;
  logic [63:0]  stall_snap;
`endif

  vx_mem_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
`ifdef MEM_RESPONDER_PERF_EN
    , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rw;
    logic [25:0]  addr;
    logic [63:0]  be;
    logic [511:0] data;
    logic [7:0]   tag;
    logic [511:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]   tag;
    logic [511:0] data;
  } rsp_t;

  localparam logic [63:0]  ALL  = '1;
  localparam logic [511:0] PA5  = {64{8'hA5}};
  localparam logic [511:0] P3C  = {64{8'h3C}};
  localparam logic [511:0] P22  = {64{8'h22}};
  localparam logic [511:0] P11  = {64{8'h11}};
  localparam logic [511:0] PFF  = {64{8'hFF}};

  vec_t vecs [12];
  rsp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A response is taken at the posedge following a negedge where valid && ready hold.
  always @(negedge clk) begin : mon
    rsp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got tag %0d expected no response", rsp_tag);
      end else begin
        e = sb.pop_front();
        chk("rsp_tag", {504'd0, rsp_tag}, {504'd0, e.tag});
        chk("rsp_data", rsp_data, e.data);
      end
    end
  end

  task automatic send(input logic rw, input logic [25:0] a, input logic [63:0] be,
                      input logic [511:0] d, input logic [7:0] t, input logic [511:0] exp,
                      input bit track);
    int g = 0;
    @(negedge clk);
    req_valid = 1; req_rw = rw; req_addr = a; req_byteen = be; req_data = d; req_tag = t;
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got req_ready 0 expected 1 within 200 cycles");
    end else if (!rw && track) sb.push_back('{tag: t, data: exp});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 512'(sb.size()), 512'd0);
  endtask

  initial begin #500000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end

  initial begin
    vecs[0]  = '{1'b1, 26'd5,     ALL,    PA5,   8'd0, '0};
    vecs[1]  = '{1'b0, 26'd5,     '0,     '0,    8'd3, PA5};
    vecs[2]  = '{1'b1, 26'd7,     ALL,    '0,    8'd0, '0};
    vecs[3]  = '{1'b1, 26'd7,     64'h1,  PFF,   8'd0, '0};
    vecs[4]  = '{1'b0, 26'd7,     '0,     '0,    8'd4, 512'hFF};
    vecs[5]  = '{1'b1, 26'h400,   ALL,    P3C,   8'd0, '0};
    vecs[6]  = '{1'b0, 26'd0,     '0,     '0,    8'd5, P3C};
    vecs[7]  = '{1'b1, 26'd9,     ALL,    P22,   8'd0, '0};
    vecs[8]  = '{1'b1, 26'd9,     '0,     P11,   8'd0, '0};
    vecs[9]  = '{1'b0, 26'd9,     '0,     '0,    8'd6, P22};
    vecs[10] = '{1'b0, 26'h405,   '0,     '0,    8'd7, PA5};
    vecs[11] = '{1'b0, 26'd7,     '0,     '0,    8'd8, 512'hFF};

    reset = 1; req_valid = 0; req_rw = 0; req_byteen = 0; req_addr = 0;
    req_data = 0; req_tag = 0; rsp_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {511'd0, req_ready}, 512'd0);
    chk("rst_rsp_valid", {511'd0, rsp_valid}, 512'd0);
    chk("rst_rsp_data", rsp_data, 512'd0);
    chk("rst_rsp_tag", {504'd0, rsp_tag}, 512'd0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_rst", {511'd0, req_ready}, 512'd1);

    // Exact read latency: rsp_valid appears in the 4th cycle after the accept cycle.
    send(1'b1, 26'd5, ALL, PA5, 8'd0, '0, 1'b0);
    send(1'b0, 26'd5, '0, '0, 8'd3, PA5, 1'b1);
    idle();
    chk("lat_c1", {511'd0, rsp_valid}, 512'd0);
    @(negedge clk); chk("lat_c2", {511'd0, rsp_valid}, 512'd0);
    @(negedge clk); chk("lat_c3", {511'd0, rsp_valid}, 512'd0);
    @(negedge clk); chk("lat_c4", {511'd0, rsp_valid}, 512'd1);
    chk("lat_tag", {504'd0, rsp_tag}, 512'd3);
    drain();

    // Back-to-back table traffic at full throughput.
    for (int i = 0; i < 12; i++)
      send(vecs[i].rw, vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].tag, vecs[i].exp, 1'b1);
    idle();
    drain();

    // Reset while three reads are in flight: they must vanish.
    send(1'b0, 26'd5, '0, '0, 8'd20, '0, 1'b0);
    send(1'b0, 26'd5, '0, '0, 8'd21, '0, 1'b0);
    send(1'b0, 26'd5, '0, '0, 8'd22, '0, 1'b0);
    #1 reset = 1; req_valid = 0;
    @(negedge clk);
    chk("midrst_rsp_valid", {511'd0, rsp_valid}, 512'd0);
    chk("midrst_req_ready", {511'd0, req_ready}, 512'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_rsp_valid", {511'd0, rsp_valid}, 512'd0);
    chk("post_rst_req_ready", {511'd0, req_ready}, 512'd1);

    // Backpressure: 8 reads fill the outstanding budget, the 9th waits.
    @(posedge clk); #1 rsp_ready = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid = 1; req_rw = 0; req_addr = 26'd5; req_tag = 8'(i);
      chk("bp_ready", {511'd0, req_ready}, {511'd0, (i < 8)});
      if (i < 8) sb.push_back('{tag: 8'(i), data: PA5});
    end
`ifdef MEM_RESPONDER_PERF_EN
    stall_snap = perf_stalls;
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_ready", {511'd0, req_ready}, 512'd0);
      chk("bp_hold_valid", {511'd0, rsp_valid}, 512'd1);
      chk("bp_hold_tag", {504'd0, rsp_tag}, 512'd0);
      chk("bp_hold_data", rsp_data, PA5);
    end
`ifdef MEM_RESPONDER_PERF_EN
    chk("perf_stalls", perf_stalls, stall_snap + 64'd4);
`endif
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    chk("full_rsp_cycle_ready", {511'd0, req_ready}, 512'd0);
    @(negedge clk);
    chk("ready_after_rsp", {511'd0, req_ready}, 512'd1);
    sb.push_back('{tag: 8'd8, data: PA5});
    @(posedge clk);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
